arcade_input_mapper: RTL and testbench

ARCADE_INPUT_MAPPER -- requirements
Module: arcade_input_mapper

---
 rtl/arcade_input_mapper.sv | 93 +++++++++
 tb/tb_arcade_input_mapper.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: PS/2 keymap + joystick merge into per-player buttons with autofire and coin stretch
module arcade_input_mapper #(
    parameter int PLAYERS  = 2,
    parameter int NBTN     = 8,
    parameter int COIN_IDX = 7,
    parameter int COIN_MIN = 400000,
    parameter int AF_DIV   = 2000000
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [10:0]             ps2_key,
    input  logic [16*PLAYERS-1:0]   joystick,
    input  logic                    merge_joy,
    input  logic                    map_we,
    input  logic [8:0]              map_addr,
    input  logic [7:0]              map_data,
    input  logic [NBTN*PLAYERS-1:0] af_mask,
    input  logic                    kbd_clear,
    output logic [NBTN*PLAYERS-1:0] btn_out
);

    localparam int W = NBTN*PLAYERS;

    logic [7:0]                    keymap [0:511];
    logic [7:0]                    map_q;
    logic                          primed, ps2_tog, ev_s1, prs_s1, key_ev, af_wrap, af_phase;
    logic [W-1:0]                  key_state, key_nxt, raw, btn_nxt;
    logic [NBTN-1:0]               joy_or;
    logic [23:0]                   af_cnt;
    logic [PLAYERS-1:0]            coin_prev, coin_raw;
    logic [PLAYERS-1:0][23:0]      coin_cnt, coin_nxt;
    logic                          unused_joy;

    assign unused_joy = ^joystick;
    assign key_ev     = primed && (ps2_key[10] != ps2_tog);
    assign af_wrap    = af_cnt == 24'(AF_DIV-1);

    // keymap survives reset; read-first so a same-cycle write is seen by the next event only
    always_ff @(posedge clk_sys) begin
        if (map_we) keymap[map_addr] <= map_data;
        map_q <= keymap[ps2_key[8:0]];
    end

    always_comb begin
        joy_or = '0;
        for (int p = 0; p < PLAYERS; p++) joy_or = joy_or | joystick[16*p +: NBTN];
        key_nxt = key_state;
        for (int p = 0; p < PLAYERS; p++)
            for (int b = 0; b < NBTN; b++)
                if (ev_s1 && map_q[7] && map_q[6:5] == 2'(p) && map_q[4:0] == 5'(b))
                    key_nxt[NBTN*p+b] = prs_s1;
        if (kbd_clear) key_nxt = '0;
        raw      = '0;
        btn_nxt  = '0;
        coin_raw = '0;
        coin_nxt = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            raw[NBTN*p +: NBTN] = key_state[NBTN*p +: NBTN] | (merge_joy ? joy_or : joystick[16*p +: NBTN]);
            coin_raw[p] = raw[NBTN*p+COIN_IDX];
            coin_nxt[p] = (coin_raw[p] && !coin_prev[p]) ? 24'(COIN_MIN) :
                          (coin_cnt[p] != '0) ? coin_cnt[p] - 24'd1 : '0;
            btn_nxt[NBTN*p +: NBTN] = raw[NBTN*p +: NBTN] & (~af_mask[NBTN*p +: NBTN] | {NBTN{af_phase}});
            btn_nxt[NBTN*p+COIN_IDX] = coin_raw[p] || coin_nxt[p] != '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed    <= 1'b0;
            ps2_tog   <= 1'b0;
            ev_s1     <= 1'b0;
            prs_s1    <= 1'b0;
            key_state <= '0;
            af_cnt    <= '0;
            af_phase  <= 1'b1;
            coin_prev <= '0;
            coin_cnt  <= '0;
            btn_out   <= '0;
        end else begin
            primed    <= 1'b1;
            ps2_tog   <= ps2_key[10];
            ev_s1     <= key_ev;
            prs_s1    <= ps2_key[9];
            key_state <= key_nxt;
            af_cnt    <= af_wrap ? '0 : af_cnt + 24'd1;
            af_phase  <= af_phase ^ af_wrap;
            coin_prev <= coin_raw;
            coin_cnt  <= coin_nxt;
            btn_out   <= btn_nxt;
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed stimulus with a cycle-tagged scoreboard checked on the falling edge
module tb_arcade_input_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [31:0] joystick;
    logic        merge_joy, map_we, kbd_clear, tog;
    logic [8:0]  map_addr;
    logic [7:0]  map_data;
    logic [15:0] af_mask, btn_out;
    int          cyc = 0, checks = 0, failures = 0, rel = 0;

    typedef struct {
        int          cyc;
        logic [15:0] mask;
        logic [15:0] val;
        bit [63:0]   tag;
    } exp_t;
    exp_t sbq[$];

    arcade_input_mapper #(
        .PLAYERS(2), .NBTN(8), .COIN_IDX(7), .COIN_MIN(10), .AF_DIV(4)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
        .merge_joy(merge_joy), .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
        .af_mask(af_mask), .kbd_clear(kbd_clear), .btn_out(btn_out)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc = cyc + 1;

    always @(negedge clk_sys) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc <= cyc) begin
                checks++;
                if (sbq[i].cyc < cyc || (btn_out & sbq[i].mask) !== (sbq[i].val & sbq[i].mask)) begin
                    failures++;
                    $display("FAIL %s cyc=%0d btn_out=%h required=%h mask=%h",
                             sbq[i].tag, cyc, btn_out, sbq[i].val, sbq[i].mask);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic expect_at(input int dc, input logic [15:0] m, input logic [15:0] v, input bit [63:0] tag);
        sbq.push_back(exp_t'{cyc + dc, m, v, tag});
    endtask

    task automatic map_write(input logic [8:0] a, input logic [7:0] d);
        map_we   = 1'b1;
        map_addr = a;
        map_data = d;
        step(1);
        map_we   = 1'b0;
    endtask

    task automatic key(input logic pr, input logic [8:0] code);
        tog     = ~tog;
        ps2_key = {tog, pr, code};
        step(1);
    endtask

    // keyboard change lands on btn_out 3 edges after the drive point: old at +2, new at +3
    task automatic key_chk(input logic pr, input logic [8:0] code, input logic [15:0] m,
                           input logic [15:0] old_v, input logic [15:0] new_v, input bit [63:0] tag);
        expect_at(2, m, old_v, tag);
        expect_at(3, m, new_v, tag);
        key(pr, code);
    endtask

    initial begin
        reset_n = 1'b0; ps2_key = '0; joystick = '0; merge_joy = 1'b0; map_we = 1'b0;
        map_addr = '0; map_data = '0; af_mask = '0; kbd_clear = 1'b0; tog = 1'b0;
        step(3);
        expect_at(0, 16'hFFFF, 16'h0000, "rst");
        step(1);
        reset_n = 1'b1;
        rel = cyc;
        step(2);
        map_write(9'h075, 8'h83);
        map_write(9'h012, 8'h83);
        map_write(9'h013, 8'hA2);
        map_write(9'h015, 8'hA5);
        map_write(9'h11C, 8'h02);
        map_write(9'h0F0, 8'hE1);
        map_write(9'h014, 8'h89);
        key_chk(1'b1, 9'h075, 16'hFFFF, 16'h0000, 16'h0008, "kb_on");   step(2);
        key_chk(1'b0, 9'h075, 16'hFFFF, 16'h0008, 16'h0000, "kb_off");  step(2);
        map_we = 1'b1; map_addr = 9'h075; map_data = 8'h84;
        key_chk(1'b1, 9'h075, 16'hFFFF, 16'h0000, 16'h0008, "rd_old");
        map_we = 1'b0;                                                  step(2);
        key_chk(1'b0, 9'h075, 16'hFFFF, 16'h0008, 16'h0008, "wr_new");  step(2);
        key_chk(1'b1, 9'h075, 16'hFFFF, 16'h0008, 16'h0018, "new_map"); step(2);
        key_chk(1'b0, 9'h075, 16'hFFFF, 16'h0018, 16'h0008, "new_rel"); step(2);
        key_chk(1'b0, 9'h012, 16'hFFFF, 16'h0008, 16'h0000, "shared");  step(2);
        map_write(9'h075, 8'h83);
        key_chk(1'b1, 9'h11C, 16'hFFFF, 16'h0000, 16'h0000, "invalid");
        key_chk(1'b1, 9'h0F0, 16'hFFFF, 16'h0000, 16'h0000, "bad_pl");
        key_chk(1'b1, 9'h014, 16'hFFFF, 16'h0000, 16'h0000, "bad_idx");
        key_chk(1'b1, 9'h0AA, 16'hFFFF, 16'h0000, 16'h0000, "unmapped");
        step(3);
        key_chk(1'b1, 9'h075, 16'h0008, 16'h0000, 16'h0008, "b2b_a");
        key_chk(1'b1, 9'h013, 16'h0400, 16'h0000, 16'h0400, "b2b_b");
        step(3);
        expect_at(2, 16'hFFFF, 16'h0408, "clr_pre");
        expect_at(3, 16'hFFFF, 16'h0000, "clr");
        expect_at(4, 16'hFFFF, 16'h0000, "clr_post");
        key(1'b1, 9'h015);
        kbd_clear = 1'b1;
        step(1);
        kbd_clear = 1'b0;
        step(3);
        merge_joy = 1'b1; joystick = 32'h0001_0000;
        expect_at(1, 16'hFFFF, 16'h0101, "merge");
        step(1);
        merge_joy = 1'b0;
        expect_at(1, 16'hFFFF, 16'h0100, "nomerge");
        step(1);
        joystick = '0;
        expect_at(1, 16'hFFFF, 16'h0000, "joy_off");
        step(2);
        for (int k = 0; k <= 11; k++)
            expect_at(k, 16'h0080, (k >= 1 && k <= 10) ? 16'h0080 : 16'h0000, "coin1");
        joystick[7] = 1'b1; step(1); joystick[7] = 1'b0; step(15);
        for (int k = 0; k <= 16; k++)
            expect_at(k, 16'h0080, (k >= 1 && k <= 15) ? 16'h0080 : 16'h0000, "coin2");
        joystick[7] = 1'b1; step(1); joystick[7] = 1'b0; step(4);
        joystick[7] = 1'b1; step(1); joystick[7] = 1'b0; step(15);
        key_chk(1'b1, 9'h013, 16'h0400, 16'h0000, 16'h0400, "pre_rst"); step(2);
        key(1'b1, 9'h075);
        reset_n = 1'b0;
        expect_at(0, 16'hFFFF, 16'h0000, "async_rst");
        tog = 1'b1;
        ps2_key = {1'b1, 1'b1, 9'h075};
        step(2);
        reset_n = 1'b1;
        rel = cyc;
        for (int k = 1; k <= 5; k++) expect_at(k, 16'hFFFF, 16'h0000, "no_ev");
        step(5);
        key_chk(1'b1, 9'h075, 16'hFFFF, 16'h0000, 16'h0008, "map_kept"); step(2);
        key_chk(1'b0, 9'h075, 16'hFFFF, 16'h0008, 16'h0000, "rel_after"); step(2);
        af_mask = 16'h0090; joystick = 32'h0000_00B0;
        for (int k = 1; k <= 16; k++)
            expect_at(k, 16'h00B0, 16'h00A0 | (((((cyc + k - rel - 1) / 4) % 2) == 0) ? 16'h0010 : 16'h0000), "autofire");
        step(17);
        joystick = '0; af_mask = '0;
        step(20);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
